// File: rtl/uart_ctrl_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE,
      GAP
   } arbState_t;

   localparam int DEFAULT_GAP_CLKS     = 217;
   localparam int DEFAULT_TIMEOUT_CLKS = 2400;

   // One counter serves both the gap and the timeout, so it is sized for the larger.
   function automatic int cntWidth(input int gapClks, input int timeoutClks);
      int maxClks;
      maxClks = (gapClks > timeoutClks) ? gapClks : timeoutClks;
      return (maxClks < 2) ? 1 : $clog2(maxClks);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first asserted request at or after the pointer, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] reqVec_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   winner_o,
   output logic               found_o
);

   localparam int SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] idx;

   always_comb begin
      winner_o = '0;
      found_o  = 1'b0;
      idx      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, ptr_i} + SUM_W'(i);
         if (idx >= SUM_W'(NUM_REQ)) begin
            idx = idx - SUM_W'(NUM_REQ);
         end
         if (!found_o && reqVec_i[idx[IDX_W-1:0]]) begin
            found_o  = 1'b1;
            winner_o = idx[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters with round-robin
// fairness, an inter-frame gap and a sticky done-timeout flag.
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int GAP_CLKS     = DEFAULT_GAP_CLKS,
   parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
   input  logic                       i_Clk,
   input  logic                       i_Rst,
   input  logic [NUM_REQ-1:0]         i_Req_DV,
   input  logic [NUM_REQ*8-1:0]       i_Req_Byte,
   output logic [NUM_REQ-1:0]         o_Req_Ack,
   output logic                       o_TX_DV,
   output logic [7:0]                 o_TX_Byte,
   input  logic                       i_TX_Active,
   input  logic                       i_TX_Done,
   output logic                       o_Busy,
   output logic [$clog2(NUM_REQ)-1:0] o_Grant_Idx,
   output logic                       o_Timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = cntWidth(GAP_CLKS, TIMEOUT_CLKS);

   arbState_t          state_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cntInc_d;
   logic [NUM_REQ-1:0] reqAck_q;
   logic               txDv_q;
   logic [7:0]         txByte_q;
   logic [IDX_W-1:0]   grantIdx_q;
   logic               timeout_q;

   logic [IDX_W-1:0]   winner;
   logic               found;
   logic [IDX_W-1:0]   nextPtr_d;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .reqVec_i (i_Req_DV),
      .ptr_i    (ptr_q),
      .winner_o (winner),
      .found_o  (found)
   );

   assign nextPtr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
   assign cntInc_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

   // Counter holds cycles since launch in LAUNCH/WAIT_DONE, cycles spent in GAP otherwise.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         reqAck_q   <= '0;
         txDv_q     <= 1'b0;
         txByte_q   <= '0;
         grantIdx_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         txDv_q   <= 1'b0;
         reqAck_q <= '0;
         case (state_q)
            IDLE: begin
               if (found && !i_TX_Active) begin
                  state_q    <= LAUNCH;
                  txDv_q     <= 1'b1;
                  reqAck_q   <= NUM_REQ'(1) << winner;
                  txByte_q   <= i_Req_Byte[winner*8 +: 8];
                  grantIdx_q <= winner;
                  ptr_q      <= nextPtr_d;
                  cnt_q      <= '0;
               end
            end
            LAUNCH: begin
               state_q <= WAIT_DONE;
               cnt_q   <= cntInc_d;
            end
            WAIT_DONE: begin
               if (i_TX_Done || (cnt_q == CNT_W'(TIMEOUT_CLKS - 1))) begin
                  if (!i_TX_Done) begin
                     timeout_q <= 1'b1;
                  end
                  cnt_q   <= '0;
                  state_q <= (GAP_CLKS == 0) ? IDLE : GAP;
               end else begin
                  cnt_q <= cntInc_d;
               end
            end
            GAP: begin
               if (cnt_q == CNT_W'(GAP_CLKS - 1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cntInc_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_Req_Ack   = reqAck_q;
   assign o_TX_DV     = txDv_q;
   assign o_TX_Byte   = txByte_q;
   assign o_Busy      = (state_q != IDLE);
   assign o_Grant_Idx = grantIdx_q;
   assign o_Timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle-by-cycle vector table followed by
// hand-written sequences for timeout, done/timeout coincidence, mid-frame reset and withdrawn requests.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 2;
   localparam int GAP_CLKS     = 3;
   localparam int TIMEOUT_CLKS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  reqDv;
   logic [15:0] reqByte;
   logic        txActive;
   logic        txDone;
   logic [1:0]  reqAck;
   logic        txDv;
   logic [7:0]  txByte;
   logic        busy;
   logic [0:0]  grantIdx;
   logic        timeoutFlag;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .GAP_CLKS     (GAP_CLKS),
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) dut (
      .i_Clk       (clk),
      .i_Rst       (rst),
      .i_Req_DV    (reqDv),
      .i_Req_Byte  (reqByte),
      .o_Req_Ack   (reqAck),
      .o_TX_DV     (txDv),
      .o_TX_Byte   (txByte),
      .i_TX_Active (txActive),
      .i_TX_Done   (txDone),
      .o_Busy      (busy),
      .o_Grant_Idx (grantIdx),
      .o_Timeout   (timeoutFlag)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  reqDv;
      logic [15:0] reqByte;
      logic        txActive;
      logic        txDone;
      logic        expDv;
      logic [1:0]  expAck;
      logic [7:0]  expByte;
      logic        expBusy;
      logic        expGrant;
      logic        expTimeout;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(input logic r, input logic [1:0] dv, input logic [15:0] b,
                                  input logic act, input logic done, input logic eDv,
                                  input logic [1:0] eAck, input logic [7:0] eByte,
                                  input logic eBusy, input logic eGrant, input logic eTo);
      vec_t v;
      v.rst = r; v.reqDv = dv; v.reqByte = b; v.txActive = act; v.txDone = done;
      v.expDv = eDv; v.expAck = eAck; v.expByte = eByte; v.expBusy = eBusy;
      v.expGrant = eGrant; v.expTimeout = eTo;
      return v;
   endfunction

   task automatic applyStimulus(input logic r, input logic [1:0] dv, input logic [15:0] b,
                                input logic act, input logic done);
      rst      = r;
      reqDv    = dv;
      reqByte  = b;
      txActive = act;
      txDone   = done;
   endtask

   // Inputs are applied between edges; outputs are sampled 1 time unit after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic eDv, input logic [1:0] eAck,
                           input logic [7:0] eByte, input logic eBusy, input logic eGrant,
                           input logic eTo);
      checkOutput({tag, ".txDv"},    txDv,        eDv);
      checkOutput({tag, ".ack"},     reqAck,      eAck);
      checkOutput({tag, ".txByte"},  txByte,      eByte);
      checkOutput({tag, ".busy"},    busy,        eBusy);
      checkOutput({tag, ".grant"},   grantIdx,    eGrant);
      checkOutput({tag, ".timeout"}, timeoutFlag, eTo);
      if (reqAck != 2'b00) begin
         checkOutput({tag, ".ackWithDv"}, txDv, 1);
         checkOutput({tag, ".ackOneHot"}, $countones(reqAck), 1);
      end
   endtask

   initial begin
      applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0, 1'b0);

      // Single request then gap, followed by contention starting from a fresh reset.
      //                 rst  req    bytes     act  done   dv  ack    byte   busy grant to
      vecs.push_back(mkVec(1, 2'b00, 16'h005A, 0, 0,   0, 2'b00, 8'h00, 0, 0, 0));
      vecs.push_back(mkVec(0, 2'b01, 16'h005A, 0, 0,   1, 2'b01, 8'h5A, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b00, 16'h005A, 1, 0,   0, 2'b00, 8'h5A, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b00, 16'h005A, 1, 0,   0, 2'b00, 8'h5A, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b00, 16'h005A, 0, 1,   0, 2'b00, 8'h5A, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b00, 16'h005A, 0, 0,   0, 2'b00, 8'h5A, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b00, 16'h005A, 0, 0,   0, 2'b00, 8'h5A, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b00, 16'h005A, 0, 0,   0, 2'b00, 8'h5A, 0, 0, 0));
      vecs.push_back(mkVec(1, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h00, 0, 0, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   1, 2'b01, 8'h11, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h11, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 1,   0, 2'b00, 8'h11, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h11, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h11, 1, 0, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h11, 0, 0, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   1, 2'b10, 8'h22, 1, 1, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h22, 1, 1, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 1,   0, 2'b00, 8'h22, 1, 1, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h22, 1, 1, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h22, 1, 1, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   0, 2'b00, 8'h22, 0, 1, 0));
      vecs.push_back(mkVec(0, 2'b11, 16'h2211, 0, 0,   1, 2'b01, 8'h11, 1, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].reqDv, vecs[i].reqByte, vecs[i].txActive, vecs[i].txDone);
         tick();
         checkAll($sformatf("vec%0d", i), vecs[i].expDv, vecs[i].expAck, vecs[i].expByte,
                  vecs[i].expBusy, vecs[i].expGrant, vecs[i].expTimeout);
      end

      // Timeout: no done pulse; flag set by the edge closing cycle launch+TIMEOUT_CLKS-1.
      applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0, 1'b0);
      tick();
      checkAll("toReset", 0, 2'b00, 8'h00, 0, 0, 0);
      applyStimulus(1'b0, 2'b01, 16'h00A5, 1'b0, 1'b0);
      tick();
      checkAll("toLaunch", 1, 2'b01, 8'hA5, 1, 0, 0);
      applyStimulus(1'b0, 2'b00, 16'h00A5, 1'b1, 1'b0);
      for (int i = 1; i < TIMEOUT_CLKS; i++) begin
         tick();
         checkOutput($sformatf("toBefore%0d", i), timeoutFlag, 0);
         checkOutput($sformatf("toBusyWait%0d", i), busy, 1);
      end
      tick();
      checkAll("toRise", 0, 2'b00, 8'hA5, 1, 0, 1);
      applyStimulus(1'b0, 2'b00, 16'h00A5, 1'b0, 1'b0);
      for (int i = 1; i < GAP_CLKS; i++) begin
         tick();
         checkOutput($sformatf("toGapBusy%0d", i), busy, 1);
      end
      tick();
      checkAll("toIdle", 0, 2'b00, 8'hA5, 0, 0, 1);
      tick();
      tick();
      checkOutput("toSticky", timeoutFlag, 1);

      // Coincidence: done arrives on the expiry cycle, so the flag must stay low.
      applyStimulus(1'b1, 2'b00, 16'h0000, 1'b0, 1'b0);
      tick();
      checkAll("coReset", 0, 2'b00, 8'h00, 0, 0, 0);
      applyStimulus(1'b0, 2'b01, 16'h003C, 1'b0, 1'b0);
      tick();
      checkAll("coLaunch", 1, 2'b01, 8'h3C, 1, 0, 0);
      applyStimulus(1'b0, 2'b00, 16'h003C, 1'b1, 1'b0);
      for (int i = 1; i < TIMEOUT_CLKS; i++) begin
         tick();
      end
      applyStimulus(1'b0, 2'b00, 16'h003C, 1'b0, 1'b1);
      tick();
      checkAll("coDone", 0, 2'b00, 8'h3C, 1, 0, 0);
      applyStimulus(1'b0, 2'b00, 16'h003C, 1'b0, 1'b0);
      for (int i = 0; i < GAP_CLKS; i++) begin
         tick();
      end
      checkAll("coIdle", 0, 2'b00, 8'h3C, 0, 0, 0);

      // Reset in WAIT_DONE while the transmitter is still shifting, with request and done present.
      applyStimulus(1'b0, 2'b01, 16'hC366, 1'b0, 1'b0);
      tick();
      checkAll("rmLaunch0", 1, 2'b01, 8'h66, 1, 0, 0);
      applyStimulus(1'b0, 2'b00, 16'hC366, 1'b1, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 2'b10, 16'hC366, 1'b1, 1'b1);
      tick();
      checkAll("rmReset", 0, 2'b00, 8'h00, 0, 0, 0);
      applyStimulus(1'b0, 2'b10, 16'hC366, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("rmHoldDv%0d", i), txDv, 0);
         checkOutput($sformatf("rmHoldBusy%0d", i), busy, 0);
      end
      applyStimulus(1'b0, 2'b10, 16'hC366, 1'b0, 1'b0);
      tick();
      checkAll("rmLaunch1", 1, 2'b10, 8'hC3, 1, 1, 0);

      // Withdrawn request: requester 1 asserts only during GAP and drops before IDLE.
      applyStimulus(1'b0, 2'b00, 16'hC366, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 2'b00, 16'hC366, 1'b0, 1'b1);
      tick();
      checkAll("wdGap0", 0, 2'b00, 8'hC3, 1, 1, 0);
      applyStimulus(1'b0, 2'b10, 16'hC366, 1'b0, 1'b0);
      tick();
      checkAll("wdGap1", 0, 2'b00, 8'hC3, 1, 1, 0);
      tick();
      checkAll("wdGap2", 0, 2'b00, 8'hC3, 1, 1, 0);
      applyStimulus(1'b0, 2'b00, 16'hC366, 1'b0, 1'b0);
      tick();
      checkAll("wdIdle", 0, 2'b00, 8'hC3, 0, 1, 0);
      tick();
      checkAll("wdStay", 0, 2'b00, 8'hC3, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
